ss_skid_slice: RTL and testbench



---
 rtl/ss_pkg.sv | 23 ++
 rtl/ss_skid_slice.sv | 112 +++++++++++
 tb/tb_ss_skid_slice.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared types and default widths for the ss stream register slice.
package ss_pkg;

    localparam int SS_DATA_W = 64;
    localparam int SS_KEEP_W = SS_DATA_W / 8;
    localparam int SS_USER_W = 1;

    // Encodings double as the occupancy count (beats held).
    typedef enum logic [1:0] {
        SS_EMPTY = 2'd0,
        SS_ONE   = 2'd1,
        SS_FULL  = 2'd2
    } ss_skid_state_t;

    // One stream beat; keep, last and user always travel with their data.
    typedef struct packed {
        logic [SS_DATA_W-1:0] data;
        logic [SS_KEEP_W-1:0] keep;
        logic                 last;
        logic [SS_USER_W-1:0] user;
    } ss_beat_t;

endpackage

// File: rtl/ss_skid_slice.sv
// Full register slice for the ss stream: registered valid/payload forward,
// registered ready backward, with a two-entry (main + skid) buffer.
module ss_skid_slice
    import ss_pkg::*;
#(
    parameter int DATA_W = SS_DATA_W,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = SS_USER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [USER_W-1:0] out_user,
    output logic [1:0]        occupancy
);

    ss_skid_state_t state_q;
    ss_skid_state_t state_d;
    ss_beat_t       main_q;
    ss_beat_t       skid_q;
    ss_beat_t       in_beat;
    logic           in_ready_q;
    logic           acc;
    logic           tx;
    logic           load_main;
    logic           main_from_skid;
    logic           load_skid;

    assign in_beat.data = in_data;
    assign in_beat.keep = in_keep;
    assign in_beat.last = in_last;
    assign in_beat.user = in_user;

    // out_valid comes straight from the state flop, so it is registered.
    assign out_valid = (state_q != SS_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_q.data;
    assign out_keep  = main_q.keep;
    assign out_last  = main_q.last;
    assign out_user  = main_q.user;
    assign occupancy = state_q;

    assign acc = in_valid && in_ready_q;
    assign tx  = out_valid && out_ready;

    // Next-state and register-load decode for the occupancy FSM.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            SS_EMPTY: begin
                if (acc) begin
                    state_d   = SS_ONE;
                    load_main = 1'b1;
                end
            end
            SS_ONE: begin
                if (acc && tx) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_d   = SS_FULL;
                    load_skid = 1'b1;
                end else if (tx) begin
                    state_d = SS_EMPTY;
                end
            end
            SS_FULL: begin
                // in_ready is low here, so no beat can be accepted.
                if (tx) begin
                    state_d        = SS_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = SS_EMPTY;
            end
        endcase
    end

    // State, registered ready and beat storage; ready depends only on next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SS_EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SS_FULL);
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_beat;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

endmodule

// File: tb/tb_ss_skid_slice.sv
// Directed and scoreboard bench for ss_skid_slice.
module tb_ss_skid_slice;
    import ss_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic [0:0]  in_user;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic [0:0]  out_user;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    ss_skid_slice #(.DATA_W(64), .KEEP_W(8), .USER_W(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .out_user(out_user),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_keep  = 8'hFF;
        in_last  = l;
        in_user  = d[0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: in_ready=%b out_valid=%b occ=%0d, want 0 0 0",
                         i, in_ready, out_valid, occupancy);
            end
        end
        checks++;
        if (out_data !== 64'h0 || out_keep !== 8'h0 || out_last !== 1'b0 || out_user !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload: data=%h keep=%h last=%b user=%b, want all 0",
                     out_data, out_keep, out_last, out_user);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b occ=%0d, want 1 0 0",
                     in_ready, out_valid, occupancy);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 64'(i), i == 16);
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(i) || out_last !== (i == 16) ||
                out_user !== 1'(i) || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL stream beat %0d: valid=%b data=%h last=%b user=%b ready=%b occ=%0d, want 1 %h %b %b 1 1",
                         i, out_valid, out_data, out_last, out_user, in_ready, occupancy,
                         64'(i), i == 16, 1'(i));
            end
        end
        drive(1'b0, 64'h0, 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: valid=%b data=%h occ=%0d ready=%b, want 1 a 1 1",
                     out_valid, out_data, occupancy, in_ready);
        end
        drive(1'b1, 64'hB, 1'b1);
        cyc();
        checks++;
        if (out_data !== 64'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: data=%h occ=%0d ready=%b, want a 2 0",
                     out_data, occupancy, in_ready);
        end
        drive(1'b0, 64'h0, 1'b0);
        cyc();
        checks++;
        if (out_data !== 64'hA || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold: data=%h occ=%0d, want a 2", out_data, occupancy);
        end
        out_ready = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hB || out_last !== 1'b1 ||
            occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b data=%h last=%b occ=%0d ready=%b, want 1 b 1 1 1",
                     out_valid, out_data, out_last, occupancy, in_ready);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_random_stall();
        ss_beat_t sb[$];
        ss_beat_t exp;
        ss_beat_t cur;
        int sent = 0;
        int recv = 0;
        int budget = 0;
        logic pending = 1'b0;
        while (recv < 1000 && budget < 20000) begin
            if (!pending && sent < 1000 && $urandom_range(1) == 1) begin
                cur.data = {$urandom, $urandom};
                cur.keep = 8'($urandom);
                cur.last = 1'($urandom);
                cur.user = 1'($urandom);
                pending  = 1'b1;
            end
            in_valid  = pending;
            in_data   = cur.data;
            in_keep   = cur.keep;
            in_last   = cur.last;
            in_user   = cur.user;
            out_ready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(1));
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: beat %h delivered with nothing outstanding", out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({out_data, out_keep, out_last, out_user} !== exp) begin
                        errors++;
                        $display("FAIL rand_beat %0d: got %h/%h/%b/%b, want %h/%h/%b/%b",
                                 recv, out_data, out_keep, out_last, out_user,
                                 exp.data, exp.keep, exp.last, exp.user);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur);
                sent++;
                pending = 1'b0;
            end
            cyc();
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 1000 || sb.size() != 0) begin
            errors++;
            $display("FAIL rand_count: received %0d outstanding %0d, want 1000 0", recv, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, 64'h55, 1'b0);
        cyc();
        drive(1'b1, 64'h66, 1'b0);
        cyc();
        checks++;
        if (occupancy !== 2'd2 || out_data !== 64'h55) begin
            errors++;
            $display("FAIL mrst_full: occ=%0d data=%h, want 2 55", occupancy, out_data);
        end
        drive(1'b0, 64'h0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL mrst_after: valid=%b occ=%0d ready=%b data=%h, want 0 0 0 0",
                     out_valid, occupancy, in_ready, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL mrst_ghost cyc %0d: valid=%b data=%h, want valid 0", i, out_valid, out_data);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mrst_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_unstable_input();
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 1'b0);
        cyc();
        drive(1'b1, 64'h22, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'hE0 + 64'(k), 1'b1);
            cyc();
            checks++;
            if (in_ready !== 1'b0 || out_data !== 64'h11 || occupancy !== 2'd2) begin
                errors++;
                $display("FAIL unst_stall %0d: ready=%b data=%h occ=%0d, want 0 11 2",
                         k, in_ready, out_data, occupancy);
            end
        end
        out_ready = 1'b1;
        drive(1'b1, 64'h33, 1'b0);
        cyc();
        checks++;
        if (out_data !== 64'h22 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL unst_skid: data=%h ready=%b occ=%0d, want 22 1 1", out_data, in_ready, occupancy);
        end
        cyc();
        checks++;
        if (out_data !== 64'h33 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL unst_new: data=%h valid=%b, want 33 1", out_data, out_valid);
        end
        drive(1'b0, 64'h0, 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL unst_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random_stall();
        test_mid_reset();
        test_unstable_input();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
